// File: rtl/friscv_mem_responder.sv
// Purpose : shared-word RAM slave for the core's instruction read port and data read/write port.
// Latency : ready pulses INST_LATENCY / DATA_LATENCY cycles after a request is accepted.
// Backpressure: each port takes one request at a time; en is ignored until one cycle after the ready pulse.
//
// Ports:
//   aclk, aresetn                       clock, asynchronous active-low reset
//   inst_en/inst_addr                   instruction read request (byte address, bits [1:0] ignored)
//   inst_rdata/inst_ready               registered instruction word and one-cycle response pulse
//   mem_en/mem_wr/mem_addr/mem_wdata/mem_strb  data request (strb bit i gates byte lane i)
//   mem_rdata/mem_ready                 registered read data (0 on writes) and one-cycle response pulse
module friscv_mem_responder #(
    parameter int    ADDRW        = 16,
    parameter int    XLEN         = 32,
    parameter int    INST_LATENCY = 1,
    parameter int    DATA_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              inst_en,
    input  logic [ADDRW-1:0]  inst_addr,
    output logic [XLEN-1:0]   inst_rdata,
    output logic              inst_ready,
    input  logic              mem_en,
    input  logic              mem_wr,
    input  logic [ADDRW-1:0]  mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN/8-1:0] mem_strb,
    output logic [XLEN-1:0]   mem_rdata,
    output logic              mem_ready
);

    localparam int IDXW   = ADDRW - 2;
    localparam int DEPTH  = 2 ** IDXW;
    localparam int NBYTES = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [XLEN-1:0] ram [0:DEPTH-1];

    // Byte-offset bits carry no meaning here; addresses are word-granular.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[1:0], mem_addr[1:0]};

    // ---------------------------------------------------------------- inst port
    state_t          inst_state, inst_next;
    logic [3:0]      inst_cnt;
    logic [IDXW-1:0] inst_idx_q;
    logic [IDXW-1:0] inst_idx;
    logic            inst_accept;
    logic            inst_load;

    assign inst_accept = (inst_state == IDLE) && inst_en;
    // With latency 1 the array is sampled on the acceptance edge itself,
    // before the capture register holds the address.
    assign inst_idx    = (inst_state == IDLE) ? inst_addr[ADDRW-1:2] : inst_idx_q;
    assign inst_load   = (inst_next == RESP) && (inst_state != RESP);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) inst_state <= IDLE;
        else          inst_state <= inst_next;
    end

    always_comb begin
        inst_next = inst_state;
        unique case (inst_state)
            IDLE:    if (inst_en) inst_next = (INST_LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (inst_cnt == 4'd1) inst_next = RESP;
            RESP:    inst_next = IDLE;
            default: inst_next = IDLE;
        endcase
    end

    always_comb begin
        inst_ready = (inst_state == RESP);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            inst_cnt   <= '0;
            inst_idx_q <= '0;
            inst_rdata <= '0;
        end else begin
            if (inst_accept) begin
                inst_cnt   <= 4'(INST_LATENCY - 1);
                inst_idx_q <= inst_addr[ADDRW-1:2];
            end else if (inst_state == WAIT) begin
                inst_cnt   <= inst_cnt - 4'd1;
            end
            if (inst_load) inst_rdata <= ram[inst_idx];
        end
    end

    // ---------------------------------------------------------------- data port
    state_t            d_state, d_next;
    logic [3:0]        d_cnt;
    logic [IDXW-1:0]   d_idx_q;
    logic              d_wr_q;
    logic [XLEN-1:0]   d_wdata_q;
    logic [NBYTES-1:0] d_strb_q;
    logic [IDXW-1:0]   d_idx;
    logic              d_wr;
    logic [XLEN-1:0]   d_wdata;
    logic [NBYTES-1:0] d_strb;
    logic              d_accept;
    logic              d_load;
    logic              d_commit;

    assign d_accept = (d_state == IDLE) && mem_en;
    assign d_idx    = (d_state == IDLE) ? mem_addr[ADDRW-1:2] : d_idx_q;
    assign d_wr     = (d_state == IDLE) ? mem_wr    : d_wr_q;
    assign d_wdata  = (d_state == IDLE) ? mem_wdata : d_wdata_q;
    assign d_strb   = (d_state == IDLE) ? mem_strb  : d_strb_q;
    assign d_load   = (d_next == RESP) && (d_state != RESP);
    // The RAM has no reset, so the commit is gated to keep a request seen
    // during reset from landing in the array.
    assign d_commit = d_load && d_wr && aresetn;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) d_state <= IDLE;
        else          d_state <= d_next;
    end

    always_comb begin
        d_next = d_state;
        unique case (d_state)
            IDLE:    if (mem_en) d_next = (DATA_LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (d_cnt == 4'd1) d_next = RESP;
            RESP:    d_next = IDLE;
            default: d_next = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (d_state == RESP);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            d_cnt     <= '0;
            d_idx_q   <= '0;
            d_wr_q    <= 1'b0;
            d_wdata_q <= '0;
            d_strb_q  <= '0;
            mem_rdata <= '0;
        end else begin
            if (d_accept) begin
                d_cnt     <= 4'(DATA_LATENCY - 1);
                d_idx_q   <= mem_addr[ADDRW-1:2];
                d_wr_q    <= mem_wr;
                d_wdata_q <= mem_wdata;
                d_strb_q  <= mem_strb;
            end else if (d_state == WAIT) begin
                d_cnt     <= d_cnt - 4'd1;
            end
            if (d_load) mem_rdata <= d_wr ? '0 : ram[d_idx];
        end
    end

    // Non-blocking write: an inst read entering RESP on the same edge sees
    // the pre-write word.
    always_ff @(posedge aclk) begin
        if (d_commit) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (d_strb[i]) ram[d_idx][8*i +: 8] <= d_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_friscv_mem_responder.sv
module tb_friscv_mem_responder;

    localparam int IL = 3;
    localparam int DL = 4;

    logic        aclk;
    logic        aresetn;
    logic        inst_en;
    logic [15:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int errors = 0;
    int checks = 0;

    // Reference memory: word index -> contents, only words the bench has written.
    logic [31:0] model [int];

    friscv_mem_responder #(
        .ADDRW(16), .XLEN(32), .INST_LATENCY(IL), .DATA_LATENCY(DL), .INIT_FILE("")
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_strb(mem_strb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Issue one inst read while idle, scramble inputs after acceptance, check
    // latency, data, single-cycle pulse and data hold.
    task automatic inst_op(input logic [15:0] addr, input string tag, output logic [31:0] rd);
        int lat;
        logic [31:0] exp;
        exp = model[int'(addr[15:2])];
        inst_en = 1'b1;
        inst_addr = addr;
        @(posedge aclk); #1;
        inst_en = 1'b0;
        inst_addr = 16'($urandom);
        lat = 1;
        while (inst_ready !== 1'b1 && lat <= 40) begin
            @(posedge aclk); #1;
            lat++;
        end
        rd = inst_rdata;
        chk({tag, "_lat"}, 32'(lat), 32'(IL));
        chk({tag, "_dat"}, inst_rdata, exp);
        @(posedge aclk); #1;
        chk({tag, "_pulse"}, 32'(inst_ready), 32'd0);
        chk({tag, "_hold"}, inst_rdata, exp);
    endtask

    task automatic data_op(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input string tag, output logic [31:0] rd);
        int lat;
        int idx;
        logic [31:0] exp;
        idx = int'(addr[15:2]);
        exp = wr ? 32'd0 : model[idx];
        mem_en = 1'b1;
        mem_wr = wr;
        mem_addr = addr;
        mem_wdata = wd;
        mem_strb = st;
        @(posedge aclk); #1;
        mem_en = 1'b0;
        mem_wr = 1'($urandom);
        mem_addr = 16'($urandom);
        mem_wdata = $urandom;
        mem_strb = 4'($urandom);
        lat = 1;
        while (mem_ready !== 1'b1 && lat <= 40) begin
            @(posedge aclk); #1;
            lat++;
        end
        rd = mem_rdata;
        chk({tag, "_lat"}, 32'(lat), 32'(DL));
        chk({tag, "_dat"}, mem_rdata, exp);
        @(posedge aclk); #1;
        chk({tag, "_pulse"}, 32'(mem_ready), 32'd0);
        chk({tag, "_hold"}, mem_rdata, exp);
        if (wr) model[idx] = merge(model.exists(idx) ? model[idx] : 32'd0, wd, st);
    endtask

    initial begin
        logic [31:0] rd, rd2, ird;
        logic [15:0] a;
        int k, ci, cd;
        bit exp_rdy;

        aresetn = 1'b0;
        inst_en = 1'b0; inst_addr = '0;
        mem_en = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_strb = '0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_inst_ready", 32'(inst_ready), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Preloaded word read through the inst port.
        data_op(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, "pre10", rd);
        inst_op(16'h0040, "inst_rd10", rd);
        chk("inst_rd10_lit", rd, 32'hDEADBEEF);

        // Partial-strobe write merges with the existing word.
        data_op(1'b1, 16'h0100, 32'h11223344, 4'hF, "pre100", rd);
        data_op(1'b1, 16'h0100, 32'hAABBCCDD, 4'b0101, "strb_wr", rd);
        data_op(1'b0, 16'h0100, 32'h0, 4'h0, "strb_rd", rd);
        chk("strb_rd_lit", rd, 32'h11BB33DD);

        // Zero-strobe write is a no-op that still responds.
        data_op(1'b1, 16'h0100, 32'h0BADF00D, 4'h0, "nostrb_wr", rd);
        data_op(1'b0, 16'h0100, 32'h0, 4'h0, "nostrb_rd", rd);

        // inst_en held high: one response every IL+1 cycles, words in order.
        for (int w = 0; w < 3; w++) data_op(1'b1, 16'(w * 4), $urandom, 4'hF, "pre_b2b", rd);
        inst_en = 1'b1;
        inst_addr = 16'h0000;
        k = 0;
        for (int c = 0; c < 3 * (IL + 1); c++) begin
            @(posedge aclk); #1;
            if (c % (IL + 1) == 0) begin
                k++;
                if (k < 3) inst_addr = 16'(k * 4);
                else inst_en = 1'b0;
            end
            exp_rdy = (c % (IL + 1)) == (IL - 1);
            chk("b2b_rdy", 32'(inst_ready), 32'(exp_rdy));
            if (exp_rdy) chk("b2b_dat", inst_rdata, model[c / (IL + 1)]);
        end

        // Inst read and data write to one word enter RESP on the same edge.
        data_op(1'b1, 16'h0200, 32'h00000001, 4'hF, "pre200", rd);
        mem_en = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0200; mem_wdata = 32'h2; mem_strb = 4'hF;
        @(posedge aclk); #1;
        mem_en = 1'b0;
        inst_en = 1'b1; inst_addr = 16'h0200;
        @(posedge aclk); #1;
        inst_en = 1'b0;
        ci = -1; cd = -1; ird = '0;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) begin @(posedge aclk); #1; end
            if (inst_ready === 1'b1 && ci < 0) begin ci = c; ird = inst_rdata; end
            if (mem_ready === 1'b1 && cd < 0) cd = c;
        end
        chk("coll_inst_cyc", 32'(ci), 32'(IL - 1));
        chk("coll_mem_cyc", 32'(cd), 32'(DL - 2));
        chk("coll_old_data", ird, 32'h00000001);
        model[16'h0200 >> 2] = 32'h00000002;
        inst_op(16'h0200, "coll_after", rd);

        // Byte offset bits are ignored.
        data_op(1'b1, 16'h0000, 32'hC0FFEE11, 4'hF, "pre0", rd);
        inst_op(16'h0003, "mis3", rd);
        inst_op(16'h0000, "mis0", rd2);
        chk("misalign_eq", rd, rd2);

        // Reset in the middle of a data write discards it.
        data_op(1'b1, 16'h0300, 32'h5A5A1234, 4'hF, "pre300", rd);
        mem_en = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0300; mem_wdata = 32'hFFFFFFFF; mem_strb = 4'hF;
        @(posedge aclk); #1;
        mem_en = 1'b0; mem_wr = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge aclk); #1;
            chk("rstx_pre_rdy", 32'(mem_ready), 32'd0);
        end
        aresetn = 1'b0;
        #1;
        chk("rstx_inst_ready", 32'(inst_ready), 32'd0);
        chk("rstx_mem_ready", 32'(mem_ready), 32'd0);
        chk("rstx_inst_rdata", inst_rdata, 32'd0);
        chk("rstx_mem_rdata", mem_rdata, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge aclk); #1;
            chk("rstx_hold_rdy", 32'({inst_ready, mem_ready}), 32'd0);
            chk("rstx_hold_dat", inst_rdata | mem_rdata, 32'd0);
        end
        aresetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge aclk); #1;
            chk("rstx_no_rdy", 32'(mem_ready), 32'd0);
        end
        data_op(1'b0, 16'h0300, 32'h0, 4'h0, "rstx_rd", rd);
        chk("rstx_rd_lit", rd, 32'h5A5A1234);

        // Randomised traffic over a small window of pre-initialised words.
        for (int w = 0; w < 16; w++) data_op(1'b1, 16'(w * 4), $urandom, 4'hF, "pre_win", rd);
        for (int n = 0; n < 40; n++) begin
            a = {10'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            case ($urandom_range(0, 2))
                0: data_op(1'b1, a, $urandom, 4'($urandom), "rnd_wr", rd);
                1: data_op(1'b0, a, $urandom, 4'($urandom), "rnd_rd", rd);
                default: inst_op(a, "rnd_inst", rd);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
